// File: rtl/dpram_wr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// dpram_wr_arbiter_pkg
// Shared definitions for the DPRAM write-port arbiter and its helpers.
//   arb_state_t : arbiter FSM state encoding (IDLE / LOCKED)
//   clog2()     : ceiling log2, used to size index and beat counters
// ----------------------------------------------------------------------------
package dpram_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Ceiling log2; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/dpram_wr_arbiter_rr_priority_pick.sv
// ----------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin first-set finder. Scans req starting at ptr,
// wrapping modulo N, and reports the first set bit.
// Ports:
//   req   : request vector
//   ptr   : index where the scan starts (must be < N)
//   grant : one-hot on the chosen request, zero if none
//   idx   : index of the chosen request, zero if none
//   any   : high when at least one request is set
// ----------------------------------------------------------------------------
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int pos;

    // Walk the offsets from farthest to nearest so the nearest set bit
    // after ptr is the last one written and therefore wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        for (int off = N - 1; off >= 0; off--) begin
            pos = (int'(ptr) + off) % N;
            if (req[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                idx        = IDX_W'(pos);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dpram_wr_arbiter.sv
// ----------------------------------------------------------------------------
// dpram_wr_arbiter
// Round-robin arbiter sharing the write port (port A) of a simple dual-port
// RAM among NUM_REQ requesters, with locked bursts of up to MAX_BURST beats.
// Ports:
//   clock_in        : write-side clock
//   reset_in        : synchronous, active-high reset
//   req_valid_in    : per-requester beat valid
//   req_last_in     : per-requester last beat of burst (qualified by valid)
//   req_addr_in     : flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data_in     : flattened data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_out   : beat accepted when valid & ready (combinational)
//   ram_wren_out    : registered RAM write enable
//   ram_address_out : registered RAM address
//   ram_data_out    : registered RAM data
//   owner_out       : current / last granted requester
//   busy_out        : high while a burst is locked
// ----------------------------------------------------------------------------
module dpram_wr_arbiter
    import dpram_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clock_in,
    input  logic                          reset_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    input  logic [NUM_REQ-1:0]            req_last_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    output logic                          ram_wren_out,
    output logic [ADDR_WIDTH-1:0]         ram_address_out,
    output logic [DATA_WIDTH-1:0]         ram_data_out,
    output logic [clog2(NUM_REQ)-1:0]     owner_out,
    output logic                          busy_out
);

    localparam int IDX_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(MAX_BURST) + 1;

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_last;
    logic               accept;

    function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] cur);
        if (int'(cur) == NUM_REQ - 1) begin
            return '0;
        end
        return cur + IDX_W'(1);
    endfunction

    rr_priority_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid_in),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Ready/accept decode and next-state logic. In IDLE ready follows the
    // round-robin pick so a released port is re-arbitrated with no dead
    // cycle; in LOCKED only the owner may write, even while it bubbles.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        beat_cnt_d    = beat_cnt_q;
        req_ready_out = '0;
        accept        = 1'b0;
        sel_idx       = (state_q == ST_IDLE) ? pick_idx : owner_q;
        sel_last      = req_last_in[sel_idx];

        if (!reset_in) begin
            if (state_q == ST_IDLE) begin
                req_ready_out = pick_grant;
                accept        = pick_any;
            end else begin
                req_ready_out = NUM_REQ'(1) << owner_q;
                accept        = req_valid_in[owner_q];
            end
        end

        if (accept) begin
            owner_d = sel_idx;
            if (state_q == ST_IDLE) begin
                if (sel_last || MAX_BURST == 1) begin
                    rr_ptr_d = next_index(sel_idx);
                end else begin
                    state_d    = ST_LOCKED;
                    beat_cnt_d = CNT_W'(1);
                end
            end else begin
                // Forced release keeps beat_cnt from ever wrapping.
                if (sel_last || (beat_cnt_q + CNT_W'(1)) == CNT_W'(MAX_BURST)) begin
                    state_d    = ST_IDLE;
                    rr_ptr_d   = next_index(owner_q);
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Registered RAM port A; address/data hold when no beat is accepted.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            ram_wren_out    <= 1'b0;
            ram_address_out <= '0;
            ram_data_out    <= '0;
        end else begin
            ram_wren_out <= accept;
            if (accept) begin
                ram_address_out <= req_addr_in[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                ram_data_out    <= req_data_in[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign owner_out = owner_q;
    assign busy_out  = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_dpram_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dpram_wr_arbiter
// Self-checking bench for dpram_wr_arbiter: a cycle-level reference model
// predicts ready/owner/busy and pushes each accepted beat into a scoreboard
// queue, which is popped whenever the RAM write enable appears.
// ----------------------------------------------------------------------------
module tb_dpram_wr_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MB = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic            clock_in;
    logic            reset_in;
    logic [N-1:0]    req_valid_in;
    logic [N-1:0]    req_last_in;
    logic [N*AW-1:0] req_addr_in;
    logic [N*DW-1:0] req_data_in;
    logic [N-1:0]    req_ready_out;
    logic            ram_wren_out;
    logic [AW-1:0]   ram_address_out;
    logic [DW-1:0]   ram_data_out;
    logic [1:0]      owner_out;
    logic            busy_out;

    int total;
    int bad;

    wr_t sb[$];

    // Reference model state
    logic          m_known;
    logic          m_locked;
    int            m_rr;
    int            m_owner;
    int            m_cnt;
    logic          m_wren;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    dpram_wr_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .req_valid_in    (req_valid_in),
        .req_last_in     (req_last_in),
        .req_addr_in     (req_addr_in),
        .req_data_in     (req_data_in),
        .req_ready_out   (req_ready_out),
        .ram_wren_out    (ram_wren_out),
        .ram_address_out (ram_address_out),
        .ram_data_out    (ram_data_out),
        .owner_out       (owner_out),
        .busy_out        (busy_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check at the falling edge, then advance the
    // model across the rising edge. chk_en adds a hand-derived ready check.
    task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] last,
                                 input logic rst, input logic use_fixed,
                                 input logic [AW-1:0] fa, input logic [DW-1:0] fd,
                                 input logic chk_en, input logic [N-1:0] exp_ready);
        logic [N-1:0] m_ready;
        logic         acc;
        int           idx;
        wr_t          item;
        wr_t          got;

        reset_in     = rst;
        req_valid_in = valid;
        req_last_in  = last;
        for (int i = 0; i < N; i++) begin
            req_addr_in[i*AW +: AW] = use_fixed ? fa : AW'($urandom);
            req_data_in[i*DW +: DW] = use_fixed ? fd : $urandom;
        end

        @(negedge clock_in);

        m_ready = '0;
        idx     = 0;
        if (!rst) begin
            if (!m_locked) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (valid[(m_rr + k) % N]) idx = (m_rr + k) % N;
                end
                if (valid != '0) m_ready[idx] = 1'b1;
            end else begin
                idx = m_owner;
                m_ready[idx] = 1'b1;
            end
        end
        acc = |(m_ready & valid);

        checkOutput("ready", 64'(req_ready_out), 64'(m_ready));
        if (chk_en) checkOutput("ready_plan", 64'(req_ready_out), 64'(exp_ready));

        if (m_known) begin
            checkOutput("wren", 64'(ram_wren_out), 64'(m_wren));
            checkOutput("addr", 64'(ram_address_out), 64'(m_addr));
            checkOutput("data", 64'(ram_data_out), 64'(m_data));
            checkOutput("owner", 64'(owner_out), 64'(m_owner));
            checkOutput("busy", 64'(busy_out), 64'(m_locked));
        end

        if (ram_wren_out === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 64'(1), 64'(0));
            end else begin
                got.addr = ram_address_out;
                got.data = ram_data_out;
                item = sb.pop_front();
                checkOutput("sb_write", 64'(got), 64'(item));
            end
        end

        if (acc && !rst) begin
            item.addr = req_addr_in[idx*AW +: AW];
            item.data = req_data_in[idx*DW +: DW];
            sb.push_back(item);
        end

        @(posedge clock_in);

        if (rst) begin
            m_known  = 1'b1;
            m_locked = 1'b0;
            m_rr     = 0;
            m_owner  = 0;
            m_cnt    = 0;
            m_wren   = 1'b0;
            m_addr   = '0;
            m_data   = '0;
        end else begin
            m_wren = acc;
            if (acc) begin
                m_addr  = item.addr;
                m_data  = item.data;
                m_owner = idx;
                if (!m_locked) begin
                    if (last[idx] || MB == 1) begin
                        m_rr = (idx + 1) % N;
                    end else begin
                        m_locked = 1'b1;
                        m_cnt    = 1;
                    end
                end else if (last[idx] || m_cnt + 1 == MB) begin
                    m_locked = 1'b0;
                    m_rr     = (idx + 1) % N;
                    m_cnt    = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
        #1;
    endtask

    task automatic cyc(input logic [N-1:0] valid, input logic [N-1:0] last,
                       input logic chk_en, input logic [N-1:0] exp_ready);
        applyStimulus(valid, last, 1'b0, 1'b0, '0, '0, chk_en, exp_ready);
    endtask

    task automatic doReset();
        applyStimulus('0, '0, 1'b1, 1'b0, '0, '0, 1'b1, 4'b0000);
        applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0, '0, '0, 1'b1, 4'b0000);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        m_known  = 1'b0;
        m_locked = 1'b0;
        m_rr     = 0;
        m_owner  = 0;
        m_cnt    = 0;
        m_wren   = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        reset_in = 1'b1;
        req_valid_in = '0;
        req_last_in  = '0;
        req_addr_in  = '0;
        req_data_in  = '0;

        doReset();

        $display("[TB] single requester burst");
        for (int b = 0; b < 3; b++) begin
            applyStimulus(4'b0001, (b == 2) ? 4'b0001 : 4'b0000, 1'b0, 1'b1,
                          AW'(8'h10 + b), DW'(32'hA0 + b), 1'b1, 4'b0001);
        end
        cyc(4'b0000, 4'b0000, 1'b1, 4'b0000);
        checkOutput("s1_busy_dropped", 64'(busy_out), 64'(0));
        checkOutput("s1_last_addr", 64'(ram_address_out), 64'(8'h12));

        $display("[TB] round-robin single beats from reset");
        doReset();
        for (int k = 0; k < 8; k++) begin
            cyc(4'b1111, 4'b1111, 1'b1, 4'(1 << (k % 4)));
        end

        $display("[TB] locked burst from req1");
        cyc(4'b0010, 4'b0000, 1'b1, 4'b0010);
        cyc(4'b0111, 4'b0000, 1'b1, 4'b0010);
        cyc(4'b0111, 4'b0000, 1'b1, 4'b0010);
        cyc(4'b0111, 4'b0010, 1'b1, 4'b0010);
        cyc(4'b0101, 4'b0101, 1'b1, 4'b0100);

        $display("[TB] forced release after max burst");
        for (int k = 0; k < 21; k++) begin
            if (k < 16)
                cyc(4'b1001, 4'b0001, 1'b1, 4'b1000);
            else if (k == 16)
                cyc(4'b1001, 4'b0001, 1'b1, 4'b0001);
            else
                cyc(4'b1001, (k == 20) ? 4'b1001 : 4'b0001, 1'b1, 4'b1000);
        end

        $display("[TB] bubble inside a burst");
        cyc(4'b0100, 4'b0000, 1'b1, 4'b0100);
        cyc(4'b0110, 4'b0000, 1'b1, 4'b0100);
        cyc(4'b0010, 4'b0000, 1'b1, 4'b0100);
        cyc(4'b0010, 4'b0000, 1'b1, 4'b0100);
        cyc(4'b0110, 4'b0100, 1'b1, 4'b0100);
        cyc(4'b0010, 4'b0010, 1'b1, 4'b0010);

        $display("[TB] reset in the middle of a burst");
        cyc(4'b0001, 4'b0000, 1'b1, 4'b0001);
        cyc(4'b0001, 4'b0000, 1'b1, 4'b0001);
        applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, '0, '0, 1'b1, 4'b0000);
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0001);
        checkOutput("rst_wren_next", 64'(ram_wren_out), 64'(1));
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0010);

        $display("[TB] random traffic");
        for (int k = 0; k < 300; k++) begin
            cyc(4'($urandom), 4'($urandom), 1'b0, '0);
        end
        cyc(4'b0000, 4'b0000, 1'b0, '0);
        cyc(4'b0000, 4'b0000, 1'b0, '0);
        checkOutput("sb_empty", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
